muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit that owns the architectural HI/LO registers and answers MULT, MULTU, DIV and DIVU requests issued by the execute stage. The execute stage starts an operation with a one-cycle request and stalls on `busy`. It reads results from `hi`/`lo` for MFHI/MFLO and writes them directly for MTHI/MTLO. One result bit is produced per cycle: shift-add for multiply, restoring division for divide.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  request strobe; sampled only while idle.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a`  in  WIDTH  multiplicand or dividend (rs); sampled with `start`.
- `b`  in  WIDTH  multiplier or divisor (rt); sampled with `start`.
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse on the cycle HI/LO first show a new result.
- `div_by_zero`  out  1  valid with `done`; high if DIV/DIVU had `b`=0.
- `hi`  out  WIDTH  HI register: product upper half or remainder.
- `lo`  out  WIDTH  LO register: product lower half or quotient.

## Operation
- States:
  - IDLE → RUN on `start` with nonzero divisor or any multiply.
  - IDLE → FIX on `start` with DIV/DIVU and `b`=0.
  - RUN → RUN while count < 31.
  - RUN → FIX after iteration 31.
  - FIX → IDLE, always.
- Start edge:
  - Latch `op`.
  - For signed ops, latch operand magnitudes plus result sign flags.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Clear the 64-bit accumulator/partial remainder and set count=0.
- RUN, multiply: if the multiplier LSB is 1, add the multiplicand to the upper accumulator with carry into a 33-bit sum. Then shift right 1.
- RUN, divide: shift {remainder, quotient} left 1 and trial-subtract the divisor from the 33-bit remainder. If nonnegative, keep the difference and set quotient bit 0.
- FIX:
  - Apply two's-complement sign fixup (negation is mod 2^64 for product, mod 2^32 each for quotient and remainder).
  - Write `hi`/`lo`.
  - Pulse `done`.
- Division results: quotient truncates toward zero.
  - DIV −2^31 / −1: `lo`=0x80000000, `hi`=0 (wrap, no trap).
- Divide by zero: `hi`=`a`, `lo`=0xFFFFFFFF, `div_by_zero`=1.
- `start` while busy (RUN/FIX) is ignored and not queued.
- MTHI/MTLO:
  - `hi_we`/`lo_we` write `wdata` on any edge where state is IDLE.
  - Ignored in RUN/FIX; FIX always owns HI/LO on its edge.
  - A write and `start` on the same IDLE edge: the write lands, and the operation later overwrites both registers.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, count=0.
- `reset` mid-operation aborts; no `done` is issued and HI/LO read 0.
- Normal operation, with the start edge as E0:
  - `busy`=1 from after E0 through E33 (RUN E1–E32, FIX at E33).
  - After E33: `busy`=0, `done`=1 for exactly one cycle, new `hi`/`lo` visible.
  - Latency is 33 cycles from request to result.
- Divide by zero: FIX at E1; `busy`=1 for one cycle, then `done` after E1.
- `busy` is registered, never combinational from `start`. The requester must hold the instruction in EX until `busy` falls.
- Back-to-back: `start` in the cycle `done` is high is accepted, since state is IDLE.
- `div_by_zero` holds until the next `done`.
- `hi`/`lo` never change during RUN (accumulator is internal).

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `done` 33 cycles after start; `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT a=−3 (0xFFFFFFFD), b=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV a=−7, b=2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). DIVU a=100, b=7 → `lo`=14, `hi`=2.
- DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0. DIVU a=5, b=0 → `done` after E1, `div_by_zero`=1, `hi`=5, `lo`=0xFFFFFFFF.
- MTLO 0x1234 while idle → `lo`=0x1234 next cycle. During RUN:
  - `hi_we` with 0xDEAD is ignored.
  - A second `start` is ignored; exactly one `done` follows.
  - `start` re-asserted in the `done` cycle launches a new 33-cycle operation.
- Assert `reset` at cycle 10 of a MULTU → `busy`, `hi`, `lo` read 0 immediately (before the next edge); no `done` follows. A fresh MULTU 6×7 afterwards gives `lo`=42, `hi`=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One result bit per cycle: shift-add multiply, restoring divide, then a sign-fixup cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    count_q;
    logic [W2-1:0]    acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic             neg_lo_q;
    logic             neg_hi_q;
    logic             dbz_pend_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [W2-1:0]    div_next;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        sign_a = ~op[0] & a[WIDTH-1];
        sign_b = ~op[0] & b[WIDTH-1];
        abs_a  = sign_a ? -a : a;
        abs_b  = sign_b ? -b : b;

        // Multiply: acc = {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, mcand_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};

        // Divide: acc = {partial remainder, dividend/quotient bits}
        div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
        div_next  = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod_fix = neg_lo_q ? -acc_q : acc_q;
        quot_fix = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_hi_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= 2'b00;
            count_q    <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (start) begin
                        op_q    <= op;
                        count_q <= '0;
                        if (op[1] && (b == '0)) begin
                            // Divide by zero skips straight to FIX with the result preloaded
                            state_q    <= StFix;
                            dbz_pend_q <= 1'b1;
                            acc_q      <= {a, {WIDTH{1'b1}}};
                            mcand_q    <= '0;
                            neg_lo_q   <= 1'b0;
                            neg_hi_q   <= 1'b0;
                        end else begin
                            state_q    <= StRun;
                            dbz_pend_q <= 1'b0;
                            neg_lo_q   <= sign_a ^ sign_b;
                            neg_hi_q   <= sign_a;
                            if (op[1]) begin
                                acc_q   <= {{WIDTH{1'b0}}, abs_a};
                                mcand_q <= abs_b;
                            end else begin
                                acc_q   <= {{WIDTH{1'b0}}, abs_b};
                                mcand_q <= abs_a;
                            end
                        end
                    end
                end
                StRun: begin
                    acc_q   <= op_q[1] ? div_next : mul_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == LastCount) state_q <= StFix;
                end
                StFix: begin
                    if (op_q[1]) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[W2-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    dbz_q   <= dbz_pend_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
